pixel_rx_decoder: RTL
=====================

Name: pixel_rx_decoder

Overview:
Receives a WS2812-style single-wire serial stream and decodes it into 24-bit pixel words, MSB first, GRB order as transmitted. Each bit is classified by its high-pulse width, and a long low gap marks the latch/frame end. The block is used to loop back and check our pixel writer output, and to accept pixel streams from an upstream controller. It runs in the system clock domain and takes an asynchronous line input.

Parameters:
HIGH_THRESH_CYC, 7, high width in CLK cycles at or above which a bit decodes as 1; below it decodes as 0.
MIN_HIGH_CYC, 2, high width below this is a glitch: error, bit discarded.
MAX_HIGH_CYC, 14, high width above this is stuck-high: error, resync.
RESET_LOW_CYC, 600, consecutive low cycles that constitute the latch gap (50 us at 12 MHz).
BITS_PER_PIXEL, 24, bits assembled per pixel word.

Ports:
CLK  input  1  system clock (12 MHz nominal)
RSTN  input  1  synchronous active-low reset
d_in  input  1  serial pixel line, asynchronous
pixel_data  output  BITS_PER_PIXEL  last completed pixel word, first received bit in MSB
pixel_valid  output  1  one-cycle pulse; pixel_data is valid this cycle
frame_end  output  1  one-cycle pulse on latch gap detection
pixel_count  output  16  pixels received since last frame_end; saturates at 0xFFFF
err  output  1  one-cycle pulse on any protocol error

Behaviour:
- Reset (RSTN low at a CLK edge): all outputs 0; shift register, bit counter and cycle counters cleared; state S_SYNC. Reset mid-pixel discards the partial word.
- Input path: 2-flop synchroniser. The line sample is s2. The line is evaluated only on s2.
- States:
  - S_SYNC: count consecutive low s2 samples; any high clears the count. At RESET_LOW_CYC go to S_LOW. No frame_end is emitted from S_SYNC. Data arriving before the first gap is ignored.
  - S_LOW: the low counter increments and saturates at RESET_LOW_CYC. s2 high: clear the high counter to 1 and go to S_HIGH. When the low counter reaches exactly RESET_LOW_CYC, pulse frame_end once.
  - S_HIGH: the high counter increments and saturates at MAX_HIGH_CYC+1.
    - s2 low: classify the pulse, clear the low counter to 1, go to S_LOW.
    - Counter exceeds MAX_HIGH_CYC: pulse err, clear the bit counter, go to S_SYNC.
- Classification on falling edge, using high count h:
  - h < MIN_HIGH_CYC: err pulse; bit dropped; bit counter unchanged.
  - Otherwise the bit is (h >= HIGH_THRESH_CYC) and is shifted in at the LSB.
  - When the bit counter reaches BITS_PER_PIXEL:
    - pixel_data is loaded and pixel_valid pulses on the next cycle.
    - The bit counter clears.
    - pixel_count increments.
- Latency: pixel_valid asserts 3 CLK cycles after the first CLK edge sampling d_in low that ends the final high pulse (2 sync + 1 register).
- frame_end:
  - A nonzero bit counter (partial pixel) also pulses err in the same cycle and discards the bits.
  - pixel_count reads 0 from the cycle after frame_end.
  - frame_end never repeats during one continuous low period.
- pixel_data holds its value until the next completed pixel. It is not cleared by frame_end.
- If pixel_valid and a frame_end would coincide (impossible with legal parameters), both pulse; the count clears after the increment.

Optional Feature:
PIXEL_RX_FILTER_EN:
- Defined: a 3-sample majority filter follows the synchroniser, and s2 is replaced by the filtered value. Single-cycle glitches are suppressed. All latencies increase by 2 cycles.
- Undefined: no filter; the latency above applies, and 1-cycle pulses are reported as err.

Test Plan:
- Reset, 600 low, then pixel 0xA53CF0 (0=5 high/10 low, 1=10 high/5 low) -> one pixel_valid, pixel_data=0xA53CF0, pixel_count=1, err never.
- Two pixels 0x000001, 0xFFFFFF then 600 low -> two pixel_valid with correct data; frame_end exactly once on the 600th low cycle; pixel_count 2 then 0.
- Synced, 1-cycle high pulse inside a pixel -> err pulse, bit dropped, following 24 legal bits yield correct pixel. With PIXEL_RX_FILTER_EN: no err.
- Line held high 20 cycles -> err once at cycle 15 of high; no pixel_valid until after a new 600-cycle low gap.
- 12 bits then 600 low -> frame_end and err same cycle, no pixel_valid, pixel_count 0.
- RSTN low 1 cycle after 10 bits -> all outputs 0; bits sent without a fresh gap are ignored; after 600 low plus 24 bits a correct pixel is decoded.

Source files
------------

// File: rtl/pixel_rx_decoder.sv
// WS2812-style single-wire receiver: pulse-width bit decode into GRB pixel words, latch-gap framing.
// Optional macro PIXEL_RX_FILTER_EN inserts a 3-sample majority filter after the synchroniser.
module pixel_rx_decoder #(
  parameter int HIGH_THRESH_CYC = 7,
  parameter int MIN_HIGH_CYC    = 2,
  parameter int MAX_HIGH_CYC    = 14,
  parameter int RESET_LOW_CYC   = 600,
  parameter int BITS_PER_PIXEL  = 24
) (
  input  logic                      CLK,
  input  logic                      RSTN,
  input  logic                      d_in,
  output logic [BITS_PER_PIXEL-1:0] pixel_data,
  output logic                      pixel_valid,
  output logic                      frame_end,
  output logic [15:0]               pixel_count,
  output logic                      err
);

  localparam int LCW = $clog2(RESET_LOW_CYC + 1);
  localparam int HCW = $clog2(MAX_HIGH_CYC + 2);
  localparam int BCW = $clog2(BITS_PER_PIXEL + 1);

  localparam logic [LCW-1:0] LOW_GAP  = LCW'(RESET_LOW_CYC);
  localparam logic [LCW-1:0] LOW_LAST = LCW'(RESET_LOW_CYC - 1);
  localparam logic [LCW-1:0] LOW_ONE  = LCW'(1);
  localparam logic [HCW-1:0] H_ONE    = HCW'(1);
  localparam logic [HCW-1:0] H_MIN    = HCW'(MIN_HIGH_CYC);
  localparam logic [HCW-1:0] H_THR    = HCW'(HIGH_THRESH_CYC);
  localparam logic [HCW-1:0] H_MAX    = HCW'(MAX_HIGH_CYC);
  localparam logic [HCW-1:0] H_SAT    = HCW'(MAX_HIGH_CYC + 1);
  localparam logic [BCW-1:0] B_ONE    = BCW'(1);
  localparam logic [BCW-1:0] B_LAST   = BCW'(BITS_PER_PIXEL - 1);

  typedef enum logic [1:0] {
    S_SYNC = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2
  } state_t;

  logic r_s1;
  logic r_s2;
  logic w_line;
  logic w_bit;

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= d_in;
      r_s2 <= r_s1;
    end
  end

`ifdef PIXEL_RX_FILTER_EN
  logic r_h1;
  logic r_h2;
  logic r_filt;

  // Majority of three consecutive samples, registered: one-sample glitches never win the vote.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      r_h1   <= 1'b0;
      r_h2   <= 1'b0;
      r_filt <= 1'b0;
    end else begin
      r_h1   <= r_s2;
      r_h2   <= r_h1;
      r_filt <= (r_s2 & r_h1) | (r_s2 & r_h2) | (r_h1 & r_h2);
    end
  end

  assign w_line = r_filt;
`else
  assign w_line = r_s2;
`endif

  state_t                    r_state;
  logic [LCW-1:0]            r_low_cnt;
  logic [HCW-1:0]            r_high_cnt;
  logic [BCW-1:0]            r_bit_cnt;
  logic [BITS_PER_PIXEL-1:0] r_shift;
  logic                      r_word_done;
  logic [BITS_PER_PIXEL-1:0] r_pixel_data;
  logic                      r_pixel_valid;
  logic                      r_frame_end;
  logic [15:0]               r_pixel_count;
  logic                      r_err;

  assign w_bit = (r_high_cnt >= H_THR);

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      r_state       <= S_SYNC;
      r_low_cnt     <= '0;
      r_high_cnt    <= '0;
      r_bit_cnt     <= '0;
      r_shift       <= '0;
      r_word_done   <= 1'b0;
      r_pixel_data  <= '0;
      r_pixel_valid <= 1'b0;
      r_frame_end   <= 1'b0;
      r_pixel_count <= '0;
      r_err         <= 1'b0;
    end else begin
      r_err         <= 1'b0;
      r_frame_end   <= 1'b0;
      r_pixel_valid <= 1'b0;
      r_word_done   <= 1'b0;

      // Word publication trails the final falling edge by one cycle.
      if (r_word_done) begin
        r_pixel_data  <= r_shift;
        r_pixel_valid <= 1'b1;
      end

      // Clearing one cycle after frame_end lets a coincident increment land first.
      if (r_frame_end) begin
        r_pixel_count <= '0;
      end else if (r_word_done && (r_pixel_count != 16'hFFFF)) begin
        r_pixel_count <= r_pixel_count + 16'd1;
      end

      case (r_state)
        S_SYNC: begin
          if (w_line) begin
            r_low_cnt <= '0;
          end else if (r_low_cnt == LOW_LAST) begin
            r_low_cnt <= LOW_GAP;
            r_state   <= S_LOW;
          end else begin
            r_low_cnt <= r_low_cnt + LOW_ONE;
          end
        end

        S_LOW: begin
          if (w_line) begin
            r_high_cnt <= H_ONE;
            r_state    <= S_HIGH;
          end else if (r_low_cnt == LOW_LAST) begin
            r_low_cnt   <= LOW_GAP;
            r_frame_end <= 1'b1;
            if (r_bit_cnt != '0) begin
              r_err     <= 1'b1;
              r_bit_cnt <= '0;
              r_shift   <= '0;
            end
          end else if (r_low_cnt != LOW_GAP) begin
            r_low_cnt <= r_low_cnt + LOW_ONE;
          end
        end

        S_HIGH: begin
          if (w_line) begin
            if (r_high_cnt >= H_MAX) begin
              r_high_cnt <= H_SAT;
              r_err      <= 1'b1;
              r_bit_cnt  <= '0;
              r_shift    <= '0;
              r_low_cnt  <= '0;
              r_state    <= S_SYNC;
            end else begin
              r_high_cnt <= r_high_cnt + H_ONE;
            end
          end else begin
            r_low_cnt <= LOW_ONE;
            r_state   <= S_LOW;
            if (r_high_cnt < H_MIN) begin
              r_err <= 1'b1;
            end else begin
              r_shift <= {r_shift[BITS_PER_PIXEL-2:0], w_bit};
              if (r_bit_cnt == B_LAST) begin
                r_bit_cnt   <= '0;
                r_word_done <= 1'b1;
              end else begin
                r_bit_cnt <= r_bit_cnt + B_ONE;
              end
            end
          end
        end

        default: begin
          r_state <= S_SYNC;
        end
      endcase
    end
  end

  assign pixel_data  = r_pixel_data;
  assign pixel_valid = r_pixel_valid;
  assign frame_end   = r_frame_end;
  assign pixel_count = r_pixel_count;
  assign err         = r_err;

endmodule
